alu_share_arbiter: RTL and testbench

Shares one signed 5-bit ALU among N requesters. Round-robin arbitration accepts one command at a time and drives the ALU control and operand pins for exactly one cycle. It then waits a fixed ALU latency, captures the 6-bit result and returns it to the requester through a tagged valid/ready response. It sits between the requesting blocks and the ALU, replacing direct drive of ALU_en/a_en/b_en/a_op/b_op/A/B.

---
 rtl/alu_share_arbiter.sv | 113 +++++++++++
 tb/tb_alu_share_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one signed 5-bit ALU among N requesters with tagged valid/ready responses; ports: clk/rst, req_* command inputs with one-hot req_ready, alu_* ALU pins and alu_c result, rsp_* response, busy
module alu_share_arbiter #(
  parameter int N = 4,
  parameter int ALU_LAT = 1,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req_valid,
  output logic [N-1:0]          req_ready,
  input  logic [N-1:0]          req_a_en,
  input  logic [N-1:0]          req_b_en,
  input  logic [3*N-1:0]        req_a_op,
  input  logic [2*N-1:0]        req_b_op,
  input  logic [5*N-1:0]        req_A,
  input  logic [5*N-1:0]        req_B,
  output logic                  alu_en,
  output logic                  alu_a_en,
  output logic                  alu_b_en,
  output logic [2:0]            alu_a_op,
  output logic [1:0]            alu_b_op,
  output logic signed [4:0]     alu_A,
  output logic signed [4:0]     alu_B,
  input  logic signed [5:0]     alu_c,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic signed [5:0]     rsp_c,
  output logic                  rsp_err,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [IDW-1:0] ptr_q, id_q, gnt_id;
  logic found, legal, accept;
  logic a_en_q, b_en_q, err_q;
  logic [2:0] a_op_q, cnt_q;
  logic [1:0] b_op_q;
  logic signed [4:0] a_q, b_q;
  logic signed [5:0] c_q;
  int j;
  always_comb begin
    found = 1'b0;
    gnt_id = '0;
    j = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr_q) + k) % N;
      if (!found && req_valid[IDW'(j)]) begin
        found = 1'b1;
        gnt_id = IDW'(j);
      end
    end
  end
  assign accept = (state_q == IDLE) && found;
  assign legal = req_a_en[gnt_id] ^ req_b_en[gnt_id];
  assign req_ready = accept ? N'(1) << gnt_id : '0;
  always_comb begin
    state_d = (state_q == IDLE)  ? (found ? (legal ? ISSUE : RESP) : IDLE) :
              (state_q == ISSUE) ? WAIT :
              (state_q == WAIT)  ? ((cnt_q == 3'd1) ? RESP : WAIT) :
                                   (rsp_ready ? IDLE : RESP);
    alu_en = state_q == ISSUE;
    alu_a_en = alu_en & a_en_q;
    alu_b_en = alu_en & b_en_q;
    alu_a_op = alu_en ? a_op_q : '0;
    alu_b_op = alu_en ? b_op_q : '0;
    alu_A = alu_en ? a_q : '0;
    alu_B = alu_en ? b_q : '0;
    rsp_valid = state_q == RESP;
    rsp_id = rsp_valid ? id_q : '0;
    rsp_c = rsp_valid ? c_q : '0;
    rsp_err = rsp_valid & err_q;
    busy = state_q != IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= IDW'(N - 1);
      id_q <= '0;
      a_en_q <= 1'b0;
      b_en_q <= 1'b0;
      a_op_q <= '0;
      b_op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      cnt_q <= '0;
      c_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ptr_q <= gnt_id;
        id_q <= gnt_id;
        a_en_q <= req_a_en[gnt_id];
        b_en_q <= req_b_en[gnt_id];
        a_op_q <= req_a_op[3*gnt_id +: 3];
        b_op_q <= req_b_op[2*gnt_id +: 2];
        a_q <= req_A[5*gnt_id +: 5];
        b_q <= req_B[5*gnt_id +: 5];
        c_q <= '0;
        err_q <= !legal;
      end
      if (state_q == ISSUE) cnt_q <= 3'(ALU_LAT);
      if (state_q == WAIT) begin
        cnt_q <= cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          c_q <= alu_c;
          err_q <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed checks of the shared-ALU arbiter with ALU latencies 1 and 3
module tb_alu_share_arbiter;
  logic clk = 1'b0, rst = 1'b1, rsp_ready = 1'b1;
  logic [3:0] req_valid = '0, req_a_en = '0, req_b_en = '0;
  logic [11:0] req_a_op = '0;
  logic [7:0] req_b_op = '0;
  logic [19:0] req_A = '0, req_B = '0;
  logic signed [5:0] alu_c = '0;
  logic [3:0] req_ready1, req_ready3;
  logic alu_en1, alu_a_en1, alu_b_en1, alu_en3, alu_a_en3, alu_b_en3;
  logic [2:0] alu_a_op1, alu_a_op3;
  logic [1:0] alu_b_op1, alu_b_op3, rsp_id1, rsp_id3;
  logic signed [4:0] alu_A1, alu_B1, alu_A3, alu_B3;
  logic rsp_valid1, rsp_err1, busy1, rsp_valid3, rsp_err3, busy3;
  logic signed [5:0] rsp_c1, rsp_c3;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  alu_share_arbiter #(.N(4), .ALU_LAT(1)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready1),
    .req_a_en(req_a_en), .req_b_en(req_b_en), .req_a_op(req_a_op), .req_b_op(req_b_op),
    .req_A(req_A), .req_B(req_B), .alu_en(alu_en1), .alu_a_en(alu_a_en1), .alu_b_en(alu_b_en1),
    .alu_a_op(alu_a_op1), .alu_b_op(alu_b_op1), .alu_A(alu_A1), .alu_B(alu_B1), .alu_c(alu_c),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_id(rsp_id1), .rsp_c(rsp_c1),
    .rsp_err(rsp_err1), .busy(busy1));
  alu_share_arbiter #(.N(4), .ALU_LAT(3)) u3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready3),
    .req_a_en(req_a_en), .req_b_en(req_b_en), .req_a_op(req_a_op), .req_b_op(req_b_op),
    .req_A(req_A), .req_B(req_B), .alu_en(alu_en3), .alu_a_en(alu_a_en3), .alu_b_en(alu_b_en3),
    .alu_a_op(alu_a_op3), .alu_b_op(alu_b_op3), .alu_A(alu_A3), .alu_B(alu_B3), .alu_c(alu_c),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_id(rsp_id3), .rsp_c(rsp_c3),
    .rsp_err(rsp_err3), .busy(busy3));
  typedef struct {
    int id; bit a_en; bit b_en; int a_op; int b_op; int a; int b; int c; int exp_c; bit exp_err;
  } vec_t;
  vec_t vecs[6];
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic set_req(input int id, input bit ae, input bit be, input int aop, input int bop, input int a, input int b);
    req_a_en[id] = ae;
    req_b_en[id] = be;
    req_a_op[3*id +: 3] = 3'(aop);
    req_b_op[2*id +: 2] = 2'(bop);
    req_A[5*id +: 5] = 5'(a);
    req_B[5*id +: 5] = 5'(b);
  endtask
  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask
  task automatic wait_idle();
    bit done = 0;
    for (int t = 0; t < 30 && !done; t++) begin
      @(negedge clk);
      done = !busy1 && !busy3;
    end
    chk("idle_timeout", int'(done), 1);
    @(posedge clk); #1;
  endtask
  task automatic run_vec(input vec_t v);
    req_a_en = '0; req_b_en = '0; req_a_op = '0; req_b_op = '0; req_A = '0; req_B = '0;
    set_req(v.id, v.a_en, v.b_en, v.a_op, v.b_op, v.a, v.b);
    req_valid = 4'(1 << v.id);
    @(negedge clk);
    chk("vec_ready", int'(req_ready1), 1 << v.id);
    @(posedge clk); #1 req_valid = '0;
    if (v.a_en != v.b_en) begin
      @(negedge clk);
      chk("vec_alu_en", int'(alu_en1), 1);
      chk("vec_alu_A", int'(alu_A1), v.a);
      chk("vec_alu_B", int'(alu_B1), v.b);
      chk("vec_alu_ops", int'({alu_a_en1, alu_b_en1, alu_a_op1, alu_b_op1}),
          (int'(v.a_en) << 6) | (int'(v.b_en) << 5) | (v.a_op << 2) | v.b_op);
      @(posedge clk); #1 alu_c = 6'(v.c);
      @(negedge clk);
      chk("vec_wait_quiet", int'({alu_en1, rsp_valid1}), 0);
      @(posedge clk); #1 alu_c = 6'sd13;
    end
    @(negedge clk);
    chk("vec_alu_en_resp", int'(alu_en1), 0);
    chk("vec_rsp_valid", int'(rsp_valid1), 1);
    chk("vec_rsp_id", int'(rsp_id1), v.id);
    chk("vec_rsp_c", int'(rsp_c1), v.exp_c);
    chk("vec_rsp_err", int'(rsp_err1), int'(v.exp_err));
    @(posedge clk); #1;
    @(negedge clk);
    chk("vec_done", int'({rsp_valid1, busy1}), 0);
    @(posedge clk); #1;
  endtask
  initial begin
    bit got;
    vecs[0] = '{1, 1, 0, 2, 0,   5,  -3,   2,   2, 0};
    vecs[1] = '{3, 0, 1, 0, 3, -16,  15,  -1,  -1, 0};
    vecs[2] = '{2, 1, 1, 7, 1,   7,   7,   9,   0, 1};
    vecs[3] = '{0, 0, 0, 3, 2,   4,   4,  20,   0, 1};
    vecs[4] = '{0, 1, 0, 5, 2,  -1,  -1,  31,  31, 0};
    vecs[5] = '{2, 0, 1, 1, 1,  15, -16, -32, -32, 0};
    @(negedge clk);
    chk("rst_outputs", int'({req_ready1, alu_en1, alu_a_en1, alu_b_en1, alu_a_op1, alu_b_op1}), 0);
    chk("rst_alu_ops", int'({alu_A1, alu_B1}), 0);
    chk("rst_rsp", int'({rsp_valid1, rsp_id1, rsp_c1, rsp_err1, busy1}), 0);
    @(posedge clk); #1 rst = 1'b0;
    foreach (vecs[i]) run_vec(vecs[i]);
    do_reset();
    req_a_en = 4'hf; req_b_en = '0; req_valid = 4'hf; rsp_ready = 1'b1;
    for (int op = 0; op < 8; op++) begin
      got = 0;
      for (int t = 0; t < 20 && !got; t++) begin
        @(negedge clk);
        got = req_ready1 != 0;
      end
      chk("rr_timeout", int'(got), 1);
      chk("rr_grant", int'(req_ready1), 1 << (op % 4));
      chk("rr_onehot", $countones(req_ready1), 1);
    end
    req_valid = '0;
    wait_idle();
    do_reset();
    rsp_ready = 1'b0; req_a_en = 4'hf; req_b_en = '0; alu_c = 6'sd11; req_valid = 4'b0011;
    @(negedge clk);
    chk("bp_first_grant", int'(req_ready1), 1);
    @(posedge clk); #1 req_valid = 4'b0010;
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      got = rsp_valid1;
    end
    chk("bp_rsp_timeout", int'(got), 1);
    alu_c = -6'sd7;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid_id", int'({rsp_valid1, rsp_id1}), 4);
      chk("bp_hold_c", int'(rsp_c1), 11);
      chk("bp_no_accept", int'({req_ready1, alu_en1}), 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    chk("bp_handshake_no_accept", int'(req_ready1), 0);
    @(negedge clk);
    chk("bp_resume_grant", int'(req_ready1), 2);
    chk("bp_valid_fell", int'(rsp_valid1), 0);
    @(posedge clk); #1 req_valid = '0;
    wait_idle();
    do_reset();
    req_a_en = 4'hf; req_b_en = '0; alu_c = 6'sd5;
    set_req(1, 1, 0, 4, 2, -16, 15);
    req_valid = 4'b0010;
    @(negedge clk);
    chk("lat_grant", int'(req_ready3), 2);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    chk("lat_issue_en", int'(alu_en3), 1);
    chk("lat_issue_A", int'(alu_A3), -16);
    chk("lat_issue_B", int'(alu_B3), 15);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat_w1", int'({alu_en3, rsp_valid3}), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat_w2", int'({alu_en3, rsp_valid3}), 0);
    @(posedge clk); #1 alu_c = -6'sd32;
    @(negedge clk);
    chk("lat_w3", int'({alu_en3, rsp_valid3}), 0);
    @(posedge clk); #1 alu_c = 6'sd7;
    @(negedge clk);
    chk("lat_rsp_valid", int'(rsp_valid3), 1);
    chk("lat_rsp_c", int'(rsp_c3), -32);
    chk("lat_rsp_id_err", int'({rsp_id3, rsp_err3}), 2);
    wait_idle();
    do_reset();
    set_req(2, 1, 0, 1, 1, 3, 3);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("rmo_grant", int'(req_ready1), 4);
    @(posedge clk); #1 req_valid = '0;
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("rmo_async_rsp", int'({rsp_valid1, rsp_id1, rsp_c1, rsp_err1}), 0);
    chk("rmo_async_ctl", int'({busy1, alu_en1, req_ready1}), 0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rmo_no_rsp", int'({rsp_valid1, busy1}), 0);
    end
    @(posedge clk); #1 req_valid = 4'b1001;
    @(negedge clk);
    chk("rmo_next_grant", int'(req_ready1), 1);
    @(posedge clk); #1 req_valid = '0;
    wait_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
